mfifo: RTL

MFIFO -- requirements
Module: mfifo

---
 rtl/mfifo.sv | 89 ++++++++
 1 files changed

// File: rtl/mfifo.sv
// rtl/mfifo.sv - multi-channel show-ahead FIFO with shared push/pop ports and sticky error flags
module mfifo #(
  parameter  int W  = 32,
  parameter  int N  = 16,
  parameter  int C  = 4,
  localparam int CW = (C > 1) ? $clog2(C) : 1,
  localparam int AW = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic [CW-1:0]      push_ch,
  input  logic [W-1:0]       push_data,
  input  logic               pop,
  input  logic [CW-1:0]      pop_ch,
  output logic [W-1:0]       pop_data,
  output logic [C-1:0]       empty,
  output logic [C-1:0]       full,
  output logic [C-1:0][AW:0] level,
  output logic               err_ovf,
  output logic               err_unf,
  input  logic               err_clr
);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]   wptr [C];
  logic [AW:0]   rptr [C];
  logic [W-1:0]  mem  [C][N];

  logic          push_vld;
  logic          pop_vld;
  logic [CW-1:0] push_sel;
  logic [CW-1:0] pop_sel;
  logic          push_ok;
  logic          pop_ok;

  always_comb begin
    for (int c = 0; c < C; c++) begin
      empty[c] = (wptr[c] == rptr[c]);
      full[c]  = (wptr[c][AW] != rptr[c][AW]) &&
                 (wptr[c][AW-1:0] == rptr[c][AW-1:0]);
      level[c] = wptr[c] - rptr[c];
    end
  end

  // Out-of-range channel indices are folded onto channel 0 for lookup only;
  // the *_vld terms keep them from being accepted.
  assign push_vld = (32'(push_ch) < 32'(C));
  assign pop_vld  = (32'(pop_ch) < 32'(C));
  assign push_sel = push_vld ? push_ch : '0;
  assign pop_sel  = pop_vld ? pop_ch : '0;

  // Acceptance looks only at registered flags, so a same-cycle pop never
  // frees room for a push and a same-cycle push never feeds a pop.
  assign push_ok = push && push_vld && !full[push_sel] && !rst;
  assign pop_ok  = pop && pop_vld && !empty[pop_sel] && !rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < C; c++) begin
        wptr[c] <= '0;
        rptr[c] <= '0;
      end
    end else begin
      if (push_ok) wptr[push_sel] <= wptr[push_sel] + (AW+1)'(1);
      if (pop_ok)  rptr[pop_sel]  <= rptr[pop_sel] + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[push_sel][wptr[push_sel][AW-1:0]] <= push_data;
  end

  assign pop_data = mem[pop_sel][rptr[pop_sel][AW-1:0]];

  // A fresh error outranks a clear issued in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_ovf <= 1'b0;
      err_unf <= 1'b0;
    end else begin
      if (push && !push_ok) err_ovf <= 1'b1;
      else if (err_clr)     err_ovf <= 1'b0;
      if (pop && !pop_ok)   err_unf <= 1'b1;
      else if (err_clr)     err_unf <= 1'b0;
    end
  end

endmodule
